mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 56 +++++
 rtl/mult_div_unit.sv | 112 +++++++++++
 2 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared MIPS definitions: ALU op codes, mult/div op codes,
// default latencies and a signed divide helper.
package mult_div_unit_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Returns {remainder, quotient}. Works on magnitudes so that
  // 0x80000000 / -1 wraps to 0x80000000 with remainder 0.
  function automatic logic [63:0] sdivmod(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] q;
    logic [31:0] r;
    ma = a[31] ? -a : a;
    mb = b[31] ? -b : b;
    if (mb == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (a[31] ^ b[31]) q = -q;
    if (a[31]) r = -r;
    return {r, q};
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS multiply/divide unit with HI/LO registers.
// Ports: clk, reset (async high), start, md_op[2:0], A, B -> busy, HI, LO.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [63:0]   res;
  logic          res_wr;

  md_op_e      op;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] div_s;
  logic [63:0] div_u;
  logic        is_mul;
  logic        is_div;
  logic        is_mthi;
  logic        is_mtlo;
  logic        b_zero;

  assign op     = md_op_e'(md_op);
  assign b_zero = (B == 32'd0);

  assign prod_s = $signed({{32{A[31]}}, A})
                * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};
  assign div_s  = sdivmod(A, B);
  assign div_u  = b_zero ? 64'd0 : {A % B, A / B};

  assign is_mul  = start &
                   ((op == MD_MULT) | (op == MD_MULTU));
  assign is_div  = start &
                   ((op == MD_DIV) | (op == MD_DIVU));
  assign is_mthi = start & (op == MD_MTHI);
  assign is_mtlo = start & (op == MD_MTLO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      cnt    <= '0;
      res    <= '0;
      res_wr <= 1'b0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          unique case (1'b1)
            is_mul: begin
              res    <= (op == MD_MULT) ? prod_s : prod_u;
              res_wr <= 1'b1;
              cnt    <= CW'(MULT_CYCLES);
              busy   <= 1'b1;
              state  <= S_RUN;
            end
            is_div: begin
              res    <= (op == MD_DIV) ? div_s : div_u;
              // divide by zero runs full length but leaves HI/LO
              res_wr <= ~b_zero;
              cnt    <= CW'(DIV_CYCLES);
              busy   <= 1'b1;
              state  <= S_RUN;
            end
            is_mthi: HI <= A;
            is_mtlo: LO <= A;
            default: ;
          endcase
        end
        S_RUN: begin
          if (cnt == CW'(1)) begin
            if (res_wr) begin
              HI <= res[63:32];
              LO <= res[31:0];
            end
            cnt   <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
